// File: rtl/frv_imem_arbiter_if.sv
// Instruction memory bus: one requester-to-memory link (request fields plus stall/response).
// master drives the request; slave returns stall and response.
interface frv_imem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic              cen;
  logic              wen;
  logic [STRB_W-1:0] strb;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              stall;
  logic              error;
  logic [XLEN-1:0]   rdata;

  modport master (
    output cen, wen, strb, addr, wdata,
    input  stall, error, rdata
  );

  modport slave (
    input  cen, wen, strb, addr, wdata,
    output stall, error, rdata
  );
endinterface

// File: rtl/frv_imem_arbiter.sv
// Two-port instruction memory arbiter: fetch (A) and debug/loader (B) share one memory bus.
// Optional fairness for A is enabled by defining FRV_IMEM_ARB_FAIR_EN.
module frv_imem_arbiter
`ifdef FRV_IMEM_ARB_FAIR_EN
#(
  parameter int unsigned MAX_B_GRANTS = 4
)
`endif
(
  input  logic                 g_clk,
  input  logic                 g_resetn,
  frv_imem_arbiter_if.slave    a_if,
  frv_imem_arbiter_if.slave    b_if,
  frv_imem_arbiter_if.master   m_if
);

  localparam logic [1:0] LOCK_NONE = 2'b00;
  localparam logic [1:0] LOCK_A    = 2'b01;
  localparam logic [1:0] LOCK_B    = 2'b10;

  logic [1:0] lock_q;
  logic [1:0] lock_d;
  logic [1:0] grant_c;
  logic       rsp_vld_q;
  logic       rsp_vld_d;
  logic       rsp_owner_q;   // 1: response belongs to B
  logic       rsp_owner_d;
  logic       accept_c;
  logic       fair_force_a_c;

`ifdef FRV_IMEM_ARB_FAIR_EN
  localparam int unsigned CNT_W = 3;

  logic [CNT_W-1:0] b_cnt_q;
  logic [CNT_W-1:0] b_cnt_d;

  // Count B accepts made while A is waiting; saturates.
  always_comb begin
    b_cnt_d = b_cnt_q;
    if ((accept_c && (grant_c == LOCK_A)) || !a_if.cen) begin
      b_cnt_d = '0;
    end else if (accept_c && (grant_c == LOCK_B) && (b_cnt_q != '1)) begin
      b_cnt_d = b_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      b_cnt_q <= '0;
    end else begin
      b_cnt_q <= b_cnt_d;
    end
  end

  assign fair_force_a_c = (b_cnt_q >= CNT_W'(MAX_B_GRANTS));
`else
  assign fair_force_a_c = 1'b0;
`endif

  // Grant selection: a held lock wins, otherwise B has priority unless fairness forces A.
  always_comb begin
    grant_c = LOCK_NONE;
    if (g_resetn) begin
      case (lock_q)
        LOCK_A:  grant_c = LOCK_A;
        LOCK_B:  grant_c = LOCK_B;
        default: begin
          if (a_if.cen && b_if.cen) begin
            grant_c = fair_force_a_c ? LOCK_A : LOCK_B;
          end else if (a_if.cen) begin
            grant_c = LOCK_A;
          end else if (b_if.cen) begin
            grant_c = LOCK_B;
          end
        end
      endcase
    end
  end

  // Request mux towards memory.
  always_comb begin
    m_if.cen   = 1'b0;
    m_if.wen   = 1'b0;
    m_if.strb  = '0;
    m_if.addr  = '0;
    m_if.wdata = '0;
    case (grant_c)
      LOCK_A: begin
        m_if.cen   = a_if.cen;
        m_if.wen   = a_if.wen;
        m_if.strb  = a_if.strb;
        m_if.addr  = a_if.addr;
        m_if.wdata = a_if.wdata;
      end
      LOCK_B: begin
        m_if.cen   = b_if.cen;
        m_if.wen   = b_if.wen;
        m_if.strb  = b_if.strb;
        m_if.addr  = b_if.addr;
        m_if.wdata = b_if.wdata;
      end
      default: ;
    endcase
  end

  assign accept_c = m_if.cen && !m_if.stall;

  // Next state: keep the lock only while the granted request is stalled.
  always_comb begin
    lock_d      = LOCK_NONE;
    rsp_vld_d   = accept_c;
    rsp_owner_d = rsp_owner_q;
    if (m_if.cen && m_if.stall) begin
      lock_d = grant_c;
    end
    if (accept_c) begin
      rsp_owner_d = (grant_c == LOCK_B);
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock_q      <= LOCK_NONE;
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign a_if.stall = a_if.cen && !((grant_c == LOCK_A) && !m_if.stall);
  assign b_if.stall = b_if.cen && !((grant_c == LOCK_B) && !m_if.stall);

  // Response routing; suppressed while reset is asserted.
  assign a_if.rdata = (g_resetn && rsp_vld_q && !rsp_owner_q) ? m_if.rdata : '0;
  assign b_if.rdata = (g_resetn && rsp_vld_q &&  rsp_owner_q) ? m_if.rdata : '0;
  assign a_if.error = g_resetn && rsp_vld_q && !rsp_owner_q && m_if.error;
  assign b_if.error = g_resetn && rsp_vld_q &&  rsp_owner_q && m_if.error;

endmodule

// File: tb/tb_frv_imem_arbiter.sv
// Directed bench for frv_imem_arbiter: per-cycle grant checks plus a response scoreboard.
// Expected fairness pattern follows FRV_IMEM_ARB_FAIR_EN.
module tb_frv_imem_arbiter;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_A    = 2'd1;
  localparam logic [1:0] G_B    = 2'd2;
`ifdef FRV_IMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic g_clk;
  logic g_resetn;
  int   n_vec;
  int   n_err;
  rsp_t sb[$];

  frv_imem_arbiter_if #(.XLEN(32)) a_bus ();
  frv_imem_arbiter_if #(.XLEN(32)) b_bus ();
  frv_imem_arbiter_if #(.XLEN(32)) m_bus ();

  frv_imem_arbiter dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .a_if     (a_bus),
    .b_if     (b_bus),
    .m_if     (m_bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive the pending response, check routing and grant, record any accept.
  task automatic step(input logic [1:0] g, input logic err_next);
    rsp_t        r;
    rsp_t        n;
    logic        e_cen;
    logic        e_wen;
    logic [3:0]  e_strb;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    r.owner = G_NONE;
    r.data  = '0;
    r.err   = 1'b0;
    if (sb.size() != 0) r = sb.pop_front();
    m_bus.rdata = (r.owner == G_NONE) ? 32'($urandom) : r.data;
    m_bus.error = (r.owner == G_NONE) ? 1'b1 : r.err;
    #2;
    if (!g_resetn) begin
      r.owner = G_NONE;
      sb.delete();
    end
    chk("a_rdata", a_bus.rdata, (r.owner == G_A) ? r.data : 32'h0);
    chk("b_rdata", b_bus.rdata, (r.owner == G_B) ? r.data : 32'h0);
    chk("a_error", 32'(a_bus.error), 32'((r.owner == G_A) && r.err));
    chk("b_error", 32'(b_bus.error), 32'((r.owner == G_B) && r.err));
    e_cen = 1'b0; e_wen = 1'b0; e_strb = '0; e_addr = '0; e_wdata = '0;
    if (g == G_A) begin
      e_cen = a_bus.cen; e_wen = a_bus.wen; e_strb = a_bus.strb;
      e_addr = a_bus.addr; e_wdata = a_bus.wdata;
    end else if (g == G_B) begin
      e_cen = b_bus.cen; e_wen = b_bus.wen; e_strb = b_bus.strb;
      e_addr = b_bus.addr; e_wdata = b_bus.wdata;
    end
    chk("m_cen",   32'(m_bus.cen),  32'(e_cen));
    chk("m_wen",   32'(m_bus.wen),  32'(e_wen));
    chk("m_strb",  32'(m_bus.strb), 32'(e_strb));
    chk("m_addr",  m_bus.addr,  e_addr);
    chk("m_wdata", m_bus.wdata, e_wdata);
    chk("a_stall", 32'(a_bus.stall), 32'(a_bus.cen && !((g == G_A) && !m_bus.stall)));
    chk("b_stall", 32'(b_bus.stall), 32'(b_bus.cen && !((g == G_B) && !m_bus.stall)));
    if (e_cen && !m_bus.stall) begin
      n.owner = g;
      n.data  = 32'($urandom);
      n.err   = err_next;
      sb.push_back(n);
    end
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    g_resetn = 1'b0;
    a_bus.cen = 1'b1; a_bus.wen = 1'b0; a_bus.strb = 4'h3;
    a_bus.addr = 32'h8000_0000; a_bus.wdata = 32'hA5A5_0001;
    b_bus.cen = 1'b0; b_bus.wen = 1'b1; b_bus.strb = 4'hC;
    b_bus.addr = 32'h0000_0200; b_bus.wdata = 32'hB5B5_0002;
    m_bus.stall = 1'b0; m_bus.error = 1'b0; m_bus.rdata = '0;

    // Reset state: no memory request, stall mirrors cen.
    step(G_NONE, 1'b0);
    b_bus.cen = 1'b1;
    step(G_NONE, 1'b0);
    g_resetn = 1'b1;
    a_bus.cen = 1'b0; b_bus.cen = 1'b0;
    step(G_NONE, 1'b0);

    // Single A request passes through; response routed to A only.
    a_bus.cen = 1'b1;
    step(G_A, 1'b0);
    a_bus.cen = 1'b0;
    step(G_NONE, 1'b0);

    // Simultaneous requests: B wins, A follows.
    a_bus.cen = 1'b1; a_bus.addr = 32'h0000_0100;
    b_bus.cen = 1'b1; b_bus.addr = 32'h0000_0200;
    step(G_B, 1'b0);
    b_bus.cen = 1'b0;
    step(G_A, 1'b0);
    a_bus.cen = 1'b0;
    step(G_NONE, 1'b0);

    // B response with error, then response valid drops.
    b_bus.cen = 1'b1; b_bus.addr = 32'h0000_0300;
    step(G_B, 1'b1);
    b_bus.cen = 1'b0;
    step(G_NONE, 1'b0);
    step(G_NONE, 1'b0);

    // A locked across a 3-cycle stall while B arrives; B goes next.
    a_bus.cen = 1'b1; a_bus.addr = 32'h0000_0400; m_bus.stall = 1'b1;
    step(G_A, 1'b0);
    b_bus.cen = 1'b1; b_bus.addr = 32'h0000_0500;
    step(G_A, 1'b0);
    step(G_A, 1'b0);
    m_bus.stall = 1'b0;
    step(G_A, 1'b0);
    a_bus.cen = 1'b0;
    step(G_B, 1'b0);
    b_bus.cen = 1'b0;
    step(G_NONE, 1'b0);

    // Locked B drops cen: no memory request, lock released next cycle.
    b_bus.cen = 1'b1; m_bus.stall = 1'b1;
    step(G_B, 1'b0);
    b_bus.cen = 1'b0; a_bus.cen = 1'b1;
    step(G_B, 1'b0);
    m_bus.stall = 1'b0;
    step(G_A, 1'b1);
    a_bus.cen = 1'b0;
    step(G_NONE, 1'b0);

    // Both held high: fairness pattern (or B only).
    a_bus.cen = 1'b1; b_bus.cen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_bus.addr = 32'h0000_1000 + 32'(i);
      step((FAIR && (i % 5 == 4)) ? G_A : G_B, 1'b0);
    end
    a_bus.cen = 1'b0; b_bus.cen = 1'b0;
    step(G_NONE, 1'b0);

    // Reset while A locked and stalled, with B counter non-zero.
    a_bus.cen = 1'b1; b_bus.cen = 1'b1;
    step(G_B, 1'b0);
    step(G_B, 1'b0);
    b_bus.cen = 1'b0; m_bus.stall = 1'b1;
    step(G_A, 1'b0);
    g_resetn = 1'b0; b_bus.cen = 1'b1;
    step(G_NONE, 1'b0);
    g_resetn = 1'b1; m_bus.stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step((FAIR && (i == 4)) ? G_A : G_B, 1'b0);
    end
    a_bus.cen = 1'b0; b_bus.cen = 1'b0;
    step(G_NONE, 1'b0);
    step(G_NONE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
